// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register.
//   - Bit positions of the control-flag vector (NOOP, ADDI, MOVI, LW, SW, WRE)
//   - Default field widths used as parameter defaults by pipe_stage_reg
//   - State encoding of the skid-mode handshake FSM
// No ports (package only).
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Control-flag bit indices. The stage treats these as opaque; only the
  // write-enable position matters, for qualifying the register-file strobe.
  localparam int CTRL_NOOP = 0;
  localparam int CTRL_ADDI = 1;
  localparam int CTRL_MOVI = 2;
  localparam int CTRL_LW   = 3;
  localparam int CTRL_SW   = 4;
  localparam int CTRL_WRE  = 5;

  // Default field widths.
  localparam int PIPE_DATA_W  = 64;
  localparam int PIPE_N_LANES = 4;
  localparam int PIPE_CTRL_W  = 6;
  localparam int PIPE_REG_W   = 5;

  // Skid-mode states:
  //   EMPTY - nothing held, out_valid low
  //   FULL  - output registers hold one payload, skid slot empty
  //   SKID  - output registers and skid slot both hold a payload
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Single-entry payload slot with a full flag. Holds the payload that arrived
// while the output registers were stalled, so that the upstream ready can be
// driven from a flop instead of from the downstream ready.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset; clears flag and payload
//   i_load   in   capture i_ctrl/i_data/i_rd and mark the slot full
//   i_clear  in   mark the slot empty (wins over i_load); payload kept stale
//   i_ctrl   in   control flags to capture
//   i_data   in   N_LANES*DATA_W lane vector to capture
//   i_rd     in   destination register index to capture
//   o_ctrl   out  stored control flags
//   o_data   out  stored lane vector
//   o_rd     out  stored destination index
//   o_full   out  slot holds a payload
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int N_LANES = PIPE_N_LANES,
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter int REG_W   = PIPE_REG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_load,
  input  logic                      i_clear,
  input  logic [CTRL_W-1:0]         i_ctrl,
  input  logic [N_LANES*DATA_W-1:0] i_data,
  input  logic [REG_W-1:0]          i_rd,
  output logic [CTRL_W-1:0]         o_ctrl,
  output logic [N_LANES*DATA_W-1:0] o_data,
  output logic [REG_W-1:0]          o_rd,
  output logic                      o_full
);

  logic              r_full;
  logic [CTRL_W-1:0] r_ctrl;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_lane [N_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_rd   <= '0;
    end else if (i_load && !i_clear) begin
      r_ctrl <= i_ctrl;
      r_rd   <= i_rd;
    end
  end

  // One register per lane; each lane is a straight slice of the flat vector.
  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane[gi] <= '0;
        end else if (i_load && !i_clear) begin
          r_lane[gi] <= i_data[gi*DATA_W +: DATA_W];
        end
      end
      assign o_data[gi*DATA_W +: DATA_W] = r_lane[gi];
    end
  endgenerate

  assign o_ctrl = r_ctrl;
  assign o_rd   = r_rd;
  assign o_full = r_full;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register with valid/ready handshake and flush.
// Carries a control-flag vector, N_LANES data lanes and a destination register
// index between two pipeline stages. One cycle latency, one payload per cycle.
//
// Build option: define PIPE_STAGE_SKID_EN to add a one-entry skid slot. In
// that build in_ready comes straight from a flop (no combinational path from
// out_ready). Without it, in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   drop stage contents and any same-cycle input
//   in_valid   in   upstream presents a payload
//   in_ready   out  stage accepts a payload this cycle
//   ctrl_in    in   control flags
//   data_in    in   lanes, lane k at [k*DATA_W +: DATA_W]
//   rd_in      in   destination register index
//   out_valid  out  output payload valid
//   out_ready  in   downstream accepts the output payload
//   ctrl_out   out  registered control flags
//   data_out   out  registered lanes
//   rd_out     out  registered destination index
//   wre_out    out  out_valid & ctrl_out[WRE_BIT], register-file write strobe
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int N_LANES = PIPE_N_LANES,
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter int REG_W   = PIPE_REG_W,
  parameter int WRE_BIT = CTRL_WRE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         ctrl_in,
  input  logic [N_LANES*DATA_W-1:0] data_in,
  input  logic [REG_W-1:0]          rd_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         ctrl_out,
  output logic [N_LANES*DATA_W-1:0] data_out,
  output logic [REG_W-1:0]          rd_out,
  output logic                      wre_out
);

  localparam int LANES_W = N_LANES * DATA_W;

  logic               r_out_valid;
  logic [CTRL_W-1:0]  r_ctrl;
  logic [LANES_W-1:0] r_data;
  logic [REG_W-1:0]   r_rd;

  logic w_it;   // input transfer this cycle
  logic w_ot;   // output transfer this cycle

  assign w_ot = r_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  skid_state_e        r_state;
  logic               w_skid_load;
  logic               w_skid_clear;
  logic               w_skid_full;
  logic [CTRL_W-1:0]  w_skid_ctrl;
  logic [LANES_W-1:0] w_skid_data;
  logic [REG_W-1:0]   w_skid_rd;

  // Ready is the inverted full flop of the skid slot: no path from out_ready.
  assign in_ready = ~w_skid_full;
  assign w_it     = in_valid & in_ready;

  // Park the input in the skid slot when the output registers are occupied
  // and not draining this cycle.
  assign w_skid_load  = ~flush & (r_state == FULL) & w_it & ~w_ot;
  // The slot empties on flush, or when its payload moves to the outputs.
  assign w_skid_clear = flush | ((r_state == SKID) & w_ot);

  pipe_skid_buf #(
    .DATA_W  (DATA_W),
    .N_LANES (N_LANES),
    .CTRL_W  (CTRL_W),
    .REG_W   (REG_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (ctrl_in),
    .i_data  (data_in),
    .i_rd    (rd_in),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data),
    .o_rd    (w_skid_rd),
    .o_full  (w_skid_full)
  );

  // Handshake FSM plus output payload registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_data      <= '0;
      r_rd        <= '0;
    end else if (flush) begin
      // Payload registers keep stale contents; only validity is dropped.
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_it) begin
            r_ctrl      <= ctrl_in;
            r_data      <= data_in;
            r_rd        <= rd_in;
            r_out_valid <= 1'b1;
            r_state     <= FULL;
          end
        end
        FULL: begin
          if (w_it && w_ot) begin
            r_ctrl <= ctrl_in;
            r_data <= data_in;
            r_rd   <= rd_in;
          end else if (w_it) begin
            // Input went into the skid slot; outputs hold.
            r_state <= SKID;
          end else if (w_ot) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so only the drain case can occur.
          if (w_ot) begin
            r_ctrl  <= w_skid_ctrl;
            r_data  <= w_skid_data;
            r_rd    <= w_skid_rd;
            r_state <= FULL;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

`else

  // A slot frees up in the same cycle the downstream takes the payload.
  assign in_ready = ~r_out_valid | out_ready;
  assign w_it     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_data      <= '0;
      r_rd        <= '0;
    end else if (flush) begin
      // Same-cycle input is dropped; payload registers keep stale contents.
      r_out_valid <= 1'b0;
    end else if (w_it) begin
      r_ctrl      <= ctrl_in;
      r_data      <= data_in;
      r_rd        <= rd_in;
      r_out_valid <= 1'b1;
    end else if (w_ot) begin
      r_out_valid <= 1'b0;
    end
  end

`endif

  assign out_valid = r_out_valid;
  assign ctrl_out  = r_ctrl;
  assign data_out  = r_data;
  assign rd_out    = r_rd;
  // Control flags ride through untouched; only the write strobe is qualified.
  assign wre_out   = r_out_valid & r_ctrl[WRE_BIT];

endmodule
